adc_cfg_rx: RTL

- Serial configuration-frame receiver. It is the far end of the ADC configuration shift interface: LOAD marks a frame, SHEN qualifies the data bits and SDI carries them MSB-first.
- Each complete frame is deserialized into a parallel word and presented with its sequential address and a one-cycle write strobe.
- Used as a loopback/readback checker and as a register-file loader inside DCFEB configuration logic.
- The full FSM, datapath and outputs are triple-modular-redundant with majority voting, consistent with the team's other configuration FSMs.

---
 rtl/adc_cfg_rx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/adc_cfg_rx.sv
// Serial configuration-frame receiver: deserializes LOAD/SHEN/SDI frames into
// addressed parallel words with a write strobe. All state is held in three voted copies.
module adc_cfg_rx #(
  parameter int         FRAME_BITS = 16,
  parameter logic [4:0] LAST_ADDR  = 5'h10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  LOAD,
  input  logic                  SHEN,
  input  logic                  SDI,
  output logic [FRAME_BITS-1:0] DATA,
  output logic [4:0]            ADDR,
  output logic                  WR,
  output logic                  ERR,
  output logic                  DONE,
  output logic                  BUSY
);

  localparam int CW = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_SHIFT = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Everything that is stored, including the registered outputs, lives in one
  // packed record so the whole machine is triplicated and voted uniformly.
  typedef struct packed {
    state_t                state;
    logic [FRAME_BITS-1:0] sreg;
    logic [CW-1:0]         cnt;
    logic [4:0]            acnt;
    logic [FRAME_BITS-1:0] data;
    logic [4:0]            addr;
    logic                  wr;
    logic                  err;
    logic                  done;
    logic                  busy;
  } tmr_t;

  localparam int TW = $bits(tmr_t);

  tmr_t          cur;
  tmr_t          nxt;
  logic [TW-1:0] vote_vec;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rep
      logic [TW-1:0] q_reg;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          q_reg <= '0;
        end else begin
          q_reg <= nxt;
        end
      end
    end
  endgenerate

  assign vote_vec = (g_rep[0].q_reg & g_rep[1].q_reg) |
                    (g_rep[0].q_reg & g_rep[2].q_reg) |
                    (g_rep[1].q_reg & g_rep[2].q_reg);
  assign cur = tmr_t'(vote_vec);

  always_comb begin
    nxt    = cur;
    nxt.wr = 1'b0;
    case (cur.state)
      S_IDLE: begin
        if (START) begin
          nxt.state = S_ARMED;
          nxt.acnt  = '0;
          nxt.err   = 1'b0;
        end
      end
      S_ARMED: begin
        if (!START) begin
          nxt.state = S_IDLE;
        end else if (LOAD) begin
          nxt.state = S_SHIFT;
          nxt.cnt   = '0;
        end
      end
      S_SHIFT: begin
        if (!START) begin
          nxt.state = S_IDLE;
        end else if (LOAD) begin
          // A fresh LOAD restarts the frame; it is only an error if bits were lost.
          if (cur.cnt != '0) nxt.err = 1'b1;
          nxt.cnt = '0;
        end else if (SHEN) begin
          nxt.sreg = {cur.sreg[FRAME_BITS-2:0], SDI};
          nxt.cnt  = cur.cnt + 1'b1;
          if (cur.cnt == CW'(FRAME_BITS - 1)) begin
            nxt.state = S_STORE;
            nxt.wr    = 1'b1;
            nxt.data  = {cur.sreg[FRAME_BITS-2:0], SDI};
            nxt.addr  = cur.acnt;
          end
        end else if (cur.cnt != '0) begin
          nxt.err   = 1'b1;
          nxt.state = S_ARMED;
        end
      end
      S_STORE: begin
        if (cur.acnt == LAST_ADDR) begin
          nxt.state = S_DONE;
        end else begin
          nxt.acnt  = cur.acnt + 5'd1;
          nxt.state = S_ARMED;
        end
      end
      S_DONE: begin
        if (!START) nxt.state = S_IDLE;
      end
      default: nxt.state = S_IDLE;
    endcase
    nxt.done = (nxt.state == S_DONE);
    nxt.busy = (nxt.state == S_ARMED) || (nxt.state == S_SHIFT) || (nxt.state == S_STORE);
  end

  assign DATA = cur.data;
  assign ADDR = cur.addr;
  assign WR   = cur.wr;
  assign ERR  = cur.err;
  assign DONE = cur.done;
  assign BUSY = cur.busy;

endmodule
